// File: rtl/shade_scheduler.sv
// Round-robin front end for a shared, non-stallable shading pipeline.
// Credit-gated issue, in-order tag FIFO and a registered FWFT output FIFO.
module shade_scheduler #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned PIX_W     = 20,
    parameter int unsigned OUT_DEPTH = 8,
    parameter int unsigned SH_LAT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_hit,
    input  logic [N_REQ*96-1:0]      req_normal,
    input  logic [N_REQ*96-1:0]      req_light,
    input  logic [N_REQ*PIX_W-1:0]   req_pix,
    output logic                     sh_valid,
    output logic                     sh_hit,
    output logic [95:0]              sh_normal,
    output logic [95:0]              sh_light,
    input  logic [23:0]              sh_shade,
    input  logic                     sh_valid_out,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [23:0]              pix_rgb,
    output logic [PIX_W-1:0]         pix_idx,
    output logic [31:0]              pix_count,
    output logic                     err
);

    localparam int unsigned VEC_W = 96;
    localparam int unsigned RGB_W = 24;
    localparam int unsigned AW    = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned GW    = $clog2(N_REQ);
    localparam int unsigned OW    = RGB_W + PIX_W;

    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    win;
    logic             found;
    logic             credit_ok;
    logic             xfer;
    logic             win_hit;
    logic [VEC_W-1:0] win_normal;
    logic [VEC_W-1:0] win_light;
    logic [PIX_W-1:0] win_pix;

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] out_count;
    logic [CNT_W-1:0] out_count_next;
    logic [AW-1:0]    tag_wp, tag_rp;
    logic [AW-1:0]    o_wp, o_rp, o_rp_next;
    logic [PIX_W-1:0] tag_mem [OUT_DEPTH];
    logic [OW-1:0]    o_mem [OUT_DEPTH];
    logic [OW-1:0]    push_data;
    logic [OW-1:0]    head_next;
    logic             tag_pop, ret_err, opush, opop;

    // Round-robin search starting after the last granted core, plus winner mux
    always_comb begin
        found      = 1'b0;
        win        = last_grant;
        win_hit    = 1'b0;
        win_normal = '0;
        win_light  = '0;
        win_pix    = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            if (!found && req_valid[(int'(last_grant) + k) % int'(N_REQ)]) begin
                found = 1'b1;
                win   = GW'((int'(last_grant) + k) % int'(N_REQ));
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win == GW'(i)) begin
                win_hit    = req_hit[i];
                win_normal = req_normal[i*VEC_W +: VEC_W];
                win_light  = req_light[i*VEC_W +: VEC_W];
                win_pix    = req_pix[i*PIX_W +: PIX_W];
            end
        end
    end

    // Inflight equals tag FIFO occupancy, so it doubles as the tag count
    assign credit_ok = ({1'b0, inflight} + {1'b0, out_count}) < (CNT_W + 1)'(OUT_DEPTH);
    assign xfer      = found && credit_ok;
    assign req_ready = xfer ? (N_REQ'(1) << win) : '0;

    assign tag_pop   = sh_valid_out && (inflight != '0);
    assign ret_err   = sh_valid_out && (inflight == '0);
    assign opush     = tag_pop;
    assign opop      = pix_valid && pix_ready;
    assign push_data = {tag_mem[tag_rp], sh_shade};
    assign o_rp_next = opop ? o_rp + AW'(1) : o_rp;

    // Next head of the output FIFO; a push into an empty slot bypasses memory
    always_comb begin
        out_count_next = out_count;
        case ({opush, opop})
            2'b10:   out_count_next = out_count + CNT_W'(1);
            2'b01:   out_count_next = out_count - CNT_W'(1);
            default: out_count_next = out_count;
        endcase
        if (out_count_next == '0)
            head_next = '0;
        else if (opush && (o_rp_next == o_wp))
            head_next = push_data;
        else
            head_next = o_mem[o_rp_next];
    end

    always_ff @(posedge clk) begin
        if (xfer)
            tag_mem[tag_wp] <= win_pix;
        if (opush)
            o_mem[o_wp] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(N_REQ - 1);
            sh_valid   <= 1'b0;
            sh_hit     <= 1'b0;
            sh_normal  <= '0;
            sh_light   <= '0;
            inflight   <= '0;
            tag_wp     <= '0;
            tag_rp     <= '0;
            out_count  <= '0;
            o_wp       <= '0;
            o_rp       <= '0;
            pix_valid  <= 1'b0;
            pix_rgb    <= '0;
            pix_idx    <= '0;
            pix_count  <= '0;
            err        <= 1'b0;
        end else begin
            sh_valid  <= xfer;
            sh_hit    <= xfer && win_hit;
            sh_normal <= xfer ? win_normal : '0;
            sh_light  <= xfer ? win_light : '0;
            if (xfer) begin
                last_grant <= win;
                tag_wp     <= tag_wp + AW'(1);
            end
            if (tag_pop)
                tag_rp <= tag_rp + AW'(1);
            case ({xfer, tag_pop})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            if (opush)
                o_wp <= o_wp + AW'(1);
            o_rp      <= o_rp_next;
            out_count <= out_count_next;
            pix_valid <= (out_count_next != '0);
            {pix_idx, pix_rgb} <= head_next;
            if (opop)
                pix_count <= pix_count + 32'd1;
            if (ret_err)
                err <= 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(opush && !opop && (out_count == CNT_W'(OUT_DEPTH))));

    a_fixed_latency: assert property (@(posedge clk) disable iff (rst)
        sh_valid |-> ##SH_LAT sh_valid_out);

endmodule

// File: tb/tb_shade_scheduler.sv
// Directed bench for shade_scheduler with a fixed-latency behavioural shading model.
module tb_shade_scheduler;

    localparam int unsigned N_REQ  = 2;
    localparam int unsigned PIX_W  = 20;
    localparam int unsigned SH_LAT = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0]         req_hit;
    logic [N_REQ*96-1:0]      req_normal;
    logic [N_REQ*96-1:0]      req_light;
    logic [N_REQ*PIX_W-1:0]   req_pix;
    logic                     sh_valid;
    logic                     sh_hit;
    logic [95:0]              sh_normal;
    logic [95:0]              sh_light;
    logic [23:0]              sh_shade;
    logic                     sh_valid_out;
    logic                     pix_valid;
    logic                     pix_ready;
    logic [23:0]              pix_rgb;
    logic [PIX_W-1:0]         pix_idx;
    logic [31:0]              pix_count;
    logic                     err;

    int errors = 0;
    int checks = 0;

    // Shading model: hit -> 0xE6E6D9 xor normal.x[23:0], miss -> 0, fixed latency
    logic [SH_LAT-1:0] pv;
    logic [23:0]       ps [SH_LAT];
    logic              force_vo;

    assign sh_valid_out = pv[SH_LAT-1] | force_vo;
    assign sh_shade     = ps[SH_LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < int'(SH_LAT); i++) ps[i] <= '0;
        end else begin
            pv    <= {pv[SH_LAT-2:0], sh_valid};
            ps[0] <= (sh_valid && sh_hit) ? (24'hE6E6D9 ^ sh_normal[23:0]) : 24'h0;
            for (int i = 1; i < int'(SH_LAT); i++) ps[i] <= ps[i-1];
        end
    end

    always #5 clk = ~clk;

    shade_scheduler #(
        .N_REQ(N_REQ), .PIX_W(PIX_W), .OUT_DEPTH(8), .SH_LAT(SH_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_hit(req_hit),
        .req_normal(req_normal), .req_light(req_light), .req_pix(req_pix),
        .sh_valid(sh_valid), .sh_hit(sh_hit), .sh_normal(sh_normal), .sh_light(sh_light),
        .sh_shade(sh_shade), .sh_valid_out(sh_valid_out),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
        .pix_idx(pix_idx), .pix_count(pix_count), .err(err)
    );

    localparam logic [95:0] UP_VEC = {32'h0, 32'h0100_0000, 32'h0};

    logic [PIX_W-1:0] exp_idx [16];
    logic [23:0]      exp_rgb [16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        force_vo  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        req_hit    = '0;
        req_normal = '0;
        req_light  = '0;
        req_pix    = '0;
        pix_ready  = 1'b0;
        do_reset();
        checks++;
        if ({sh_valid, sh_hit, sh_normal, sh_light, pix_valid, pix_rgb, pix_idx, pix_count, err, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: sh_valid=%b pix_valid=%b pix_count=%0d err=%b req_ready=%b, all expected 0",
                     sh_valid, pix_valid, pix_count, err, req_ready);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_priority: req_ready=%b expected 01", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single;
        do_reset();
        pix_ready  = 1'b1;
        req_hit    = 2'b01;
        req_normal = {96'h0, UP_VEC};
        req_light  = {96'h0, UP_VEC};
        req_pix    = {20'd0, 20'd5};
        req_valid  = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b expected 01", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (sh_valid !== 1'b1 || sh_hit !== 1'b1 || sh_normal !== UP_VEC || sh_light !== UP_VEC) begin
            errors++;
            $display("FAIL single_issue: sh_valid=%b sh_hit=%b sh_normal=%h expected 1 1 %h",
                     sh_valid, sh_hit, sh_normal, UP_VEC);
        end
        tick();
        checks++;
        if (sh_valid !== 1'b0 || sh_normal !== 96'h0) begin
            errors++;
            $display("FAIL single_issue_clear: sh_valid=%b sh_normal=%h expected 0 0", sh_valid, sh_normal);
        end
        repeat (3) tick();
        checks++;
        if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: pix_valid=%b expected 0 at T+5", pix_valid);
        end
        tick();
        checks++;
        if (pix_valid !== 1'b1 || pix_idx !== 20'd5 || pix_rgb !== 24'hE6E6D9 || pix_count !== 32'd0) begin
            errors++;
            $display("FAIL single_result: valid=%b idx=%0d rgb=%h count=%0d expected 1 5 e6e6d9 0",
                     pix_valid, pix_idx, pix_rgb, pix_count);
        end
        tick();
        checks++;
        if (pix_count !== 32'd1 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_count: pix_count=%0d pix_valid=%b expected 1 0", pix_count, pix_valid);
        end
    endtask

    task automatic test_alternate;
        int n0;
        int n1;
        int got;
        logic [N_REQ-1:0] want;
        n0 = 0;
        n1 = 0;
        do_reset();
        pix_ready  = 1'b0;
        req_hit    = 2'b11;
        req_normal = {32'h0, 32'h0100_0000, 32'h2, 32'h0, 32'h0100_0000, 32'h1};
        req_light  = {UP_VEC, UP_VEC};
        req_valid  = 2'b11;
        for (int i = 0; i < 8; i++) begin
            req_pix = {20'(200 + i), 20'(100 + i)};
            #1;
            want = (i % 2 == 1) ? 2'b10 : 2'b01;
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL alt_grant_%0d: req_ready=%b expected %b", i, req_ready, want);
            end
            if (req_ready[0]) n0++;
            if (req_ready[1]) n1++;
            exp_idx[i] = (i % 2 == 1) ? 20'(200 + i) : 20'(100 + i);
            exp_rgb[i] = (i % 2 == 1) ? 24'hE6E6DB : 24'hE6E6D8;
            tick();
        end
        req_valid = '0;
        checks++;
        if (n0 != 4 || n1 != 4) begin
            errors++;
            $display("FAIL alt_fairness: core0=%0d core1=%0d grants, expected 4 4", n0, n1);
        end
        pix_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (pix_valid && got < 8) begin
                checks++;
                if (pix_idx !== exp_idx[got] || pix_rgb !== exp_rgb[got]) begin
                    errors++;
                    $display("FAIL alt_order_%0d: idx=%0d rgb=%h expected %0d %h",
                             got, pix_idx, pix_rgb, exp_idx[got], exp_rgb[got]);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 8 || pix_count !== 32'd8) begin
            errors++;
            $display("FAIL alt_drain: pixels=%0d pix_count=%0d expected 8 8", got, pix_count);
        end
    endtask

    task automatic test_miss;
        int c;
        do_reset();
        pix_ready  = 1'b1;
        req_hit    = 2'b00;
        req_normal = {96'h0, UP_VEC};
        req_light  = {96'h0, UP_VEC};
        req_pix    = {20'd0, 20'd9};
        req_valid  = 2'b01;
        tick();
        req_valid = '0;
        c = 0;
        while (!pix_valid && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (pix_valid !== 1'b1 || pix_rgb !== 24'h0 || pix_idx !== 20'd9) begin
            errors++;
            $display("FAIL miss_result: valid=%b rgb=%h idx=%0d expected 1 000000 9", pix_valid, pix_rgb, pix_idx);
        end
        tick();
    endtask

    task automatic test_backpressure;
        int nx;
        int got;
        do_reset();
        pix_ready  = 1'b0;
        req_hit    = 2'b11;
        req_normal = {UP_VEC, UP_VEC};
        req_light  = {UP_VEC, UP_VEC};
        req_valid  = 2'b11;
        nx = 0;
        for (int i = 0; i < 16; i++) begin
            req_pix = {20'(400 + i), 20'(300 + i)};
            #1;
            if (req_ready != '0) begin
                if (nx < 16) exp_idx[nx] = req_ready[1] ? 20'(400 + i) : 20'(300 + i);
                nx++;
            end
            tick();
        end
        checks++;
        if (nx != 8) begin
            errors++;
            $display("FAIL bp_transfers: transfers=%0d expected 8", nx);
        end
        checks++;
        if (req_ready !== 2'b00 || pix_valid !== 1'b1 || pix_idx !== exp_idx[0]) begin
            errors++;
            $display("FAIL bp_stalled: req_ready=%b valid=%b idx=%0d expected 00 1 %0d",
                     req_ready, pix_valid, pix_idx, exp_idx[0]);
        end
        pix_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_before_pop: req_ready=%b expected 00", req_ready);
        end
        tick();
        checks++;
        if (req_ready === 2'b00) begin
            errors++;
            $display("FAIL bp_resume: req_ready=%b expected nonzero after first pop", req_ready);
        end
        req_valid = '0;
        got = 1;
        for (int c = 0; c < 20; c++) begin
            if (pix_valid && got < 8) begin
                checks++;
                if (pix_idx !== exp_idx[got]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: idx=%0d expected %0d", got, pix_idx, exp_idx[got]);
                end
                got++;
            end else if (pix_valid) begin
                got++;
            end
            tick();
        end
        checks++;
        if (got != 8 || pix_count !== 32'd8) begin
            errors++;
            $display("FAIL bp_drain: pixels=%0d pix_count=%0d expected 8 8", got, pix_count);
        end
    endtask

    task automatic test_midreset;
        int c;
        logic seen;
        do_reset();
        pix_ready  = 1'b1;
        req_hit    = 2'b01;
        req_normal = {96'h0, UP_VEC};
        req_light  = {96'h0, UP_VEC};
        req_valid  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_pix = {20'd0, 20'(30 + i)};
            tick();
        end
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({sh_valid, sh_hit, sh_normal, sh_light, pix_valid, pix_rgb, pix_idx, pix_count, err, req_ready} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: sh_valid=%b pix_valid=%b pix_idx=%0d pix_count=%0d err=%b, all expected 0",
                     sh_valid, pix_valid, pix_idx, pix_count, err);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pix_valid || err) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: stale pixel or err seen=%b expected 0", seen);
        end
        req_pix   = {20'd0, 20'd40};
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        c = 0;
        while (!pix_valid && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (pix_valid !== 1'b1 || pix_idx !== 20'd40 || pix_rgb !== 24'hE6E6D9) begin
            errors++;
            $display("FAIL midreset_fresh: valid=%b idx=%0d rgb=%h expected 1 40 e6e6d9", pix_valid, pix_idx, pix_rgb);
        end
        tick();
        checks++;
        if (pix_count !== 32'd1) begin
            errors++;
            $display("FAIL midreset_count: pix_count=%0d expected 1", pix_count);
        end
    endtask

    task automatic test_error;
        do_reset();
        pix_ready = 1'b1;
        force_vo  = 1'b1;
        tick();
        force_vo = 1'b0;
        checks++;
        if (err !== 1'b1 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_set: err=%b pix_valid=%b expected 1 0", err, pix_valid);
        end
        repeat (4) tick();
        checks++;
        if (err !== 1'b1 || pix_valid !== 1'b0 || pix_count !== 32'd0) begin
            errors++;
            $display("FAIL err_hold: err=%b pix_valid=%b pix_count=%0d expected 1 0 0", err, pix_valid, pix_count);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b expected 0", err);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        force_vo  = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_miss();
        test_backpressure();
        test_midreset();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shade_scheduler.md
# shade_scheduler

Round-robin scheduler that shares one `shading` pipeline between `N_REQ` ray-march cores and reorders nothing: results leave in issue order, each tagged with its pixel index. The shading pipeline has no stall input, so the block issues work only when an output slot is guaranteed, using a credit counter. It sits between the ray-march cores and the frame-buffer writer.

## Interface
- `N_REQ`, 2: number of requesting cores (2..8).
- `PIX_W`, 20: pixel index width.
- `OUT_DEPTH`, 8: output FIFO depth, power of two; also the credit limit.
- `SH_LAT`, 4: shading pipeline latency in cycles, `valid_in` to `valid_out`. Used only for verification checks.
---
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-core request valid.
- `req_ready` out N_REQ: per-core grant. A transfer happens on `req_valid[i] & req_ready[i]`.
- `req_hit` in N_REQ: per-core hit flag.
- `req_normal` in N_REQ*96: per-core normal, packed as vec3 (x,y,z), Q8.24, core 0 in the LSBs.
- `req_light` in N_REQ*96: per-core light vector, same packing as `req_normal`.
- `req_pix` in N_REQ*PIX_W: per-core pixel index.
- `sh_valid` out 1: to shading `valid_in`.
- `sh_hit` out 1: to shading `hit_in`.
- `sh_normal` out 96: to shading `normal_vec`.
- `sh_light` out 96: to shading `light_vec`.
- `sh_shade` in 24: from shading `shade_out` (RGB888).
- `sh_valid_out` in 1: from shading `valid_out`.
- `pix_valid` out 1: output pixel valid.
- `pix_ready` in 1: output pixel ready.
- `pix_rgb` out 24: output colour.
- `pix_idx` out PIX_W: output pixel index.
- `pix_count` out 32: running count of pixels accepted at the output; wraps.
- `err` out 1: sticky flag, set when `sh_valid_out` arrives with the tag FIFO empty.

## Operation
- Credit: `credits_used = inflight + out_count`.
  - `inflight` increments on an issue and decrements on `sh_valid_out`.
  - `out_count` is the output FIFO occupancy.
  - An issue is allowed only when `credits_used < OUT_DEPTH`.
  - When an issue and a return happen in the same cycle, the counter nets to no change.
- Arbitration: round-robin, one grant per cycle.
  - Search starts at `(last_grant+1) mod N_REQ`; first core with `req_valid` high wins.
  - `req_ready` is combinational: one-hot on the winner when credit is available, otherwise all zero.
  - `last_grant` updates only on a completed transfer.
  - After reset `last_grant = N_REQ-1`, so core 0 has priority first.
- Issue register: on a transfer, the winner's hit, normal and light are registered onto `sh_*` with `sh_valid=1` the next cycle. With no transfer, `sh_valid=0` and the `sh_*` data registers are cleared to 0.
- Tag FIFO (depth `OUT_DEPTH`): the pixel index is pushed on each transfer.
  - On `sh_valid_out`, one tag is popped and `{tag, sh_shade}` is written into the output FIFO.
  - Misses are issued like hits; shading returns 0x000000 for them.
- Output FIFO (depth `OUT_DEPTH`): first-word-fall-through, registered.
  - `pix_valid = !empty`.
  - A pop on `pix_valid & pix_ready` increments `pix_count`.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - Overflow cannot occur by construction; an assertion checks this.
- Error: `sh_valid_out` with the tag FIFO empty sets `err`, drops the shade value and leaves the counters unchanged. `err` clears only on `rst`.

## Timing
- Reset: `rst` high at a rising edge clears the following next cycle.
  - Outputs: `sh_valid`, `sh_hit`, `sh_normal`, `sh_light`, `pix_valid`, `pix_rgb`, `pix_idx`, `pix_count` and `err` go to 0; `req_ready` also reads 0.
  - Internal state: both FIFOs empty, `inflight` = 0, `last_grant` = N_REQ-1.
- Reset mid-operation discards all in-flight work. The shading unit has its own reset and must be reset in the same cycle by the integrator. Returns arriving after reset are counted as errors.
- Latency: a transfer at edge T gives `sh_valid` high in cycle T+1. The shading result arrives at T+1+SH_LAT. `pix_valid` rises one cycle after that, at T+2+SH_LAT (T+6 at default).
- Throughput: one pixel per cycle sustained while `pix_ready` is held high.
- Backpressure: with `pix_ready` low, at most `OUT_DEPTH` issues are accepted, then `req_ready` stays 0 until the first pop.

## Test plan
- Single request on core 0 (hit, normal=(0,1,0), light=(0,1,0), pix=5) with `pix_ready=1` → `pix_valid` at T+6 with `pix_idx=5`, `pix_rgb` matching the shading model (0xE6E6D9 ±1 LSB), `pix_count=1`.
- Both cores valid every cycle for 8 cycles → grants alternate 0,1,0,1…; output `pix_idx` values come out in grant order; each core receives 4 grants.
- Miss request (`req_hit=0`, pix=9) → `pix_rgb=0x000000`, `pix_idx=9`.
- `pix_ready=0` with continuous requests → exactly 8 transfers, then `req_ready` stays 0. Raising `pix_ready` drains 8 pixels in order, and issuing resumes on the cycle after the first pop.
- Reset asserted with 3 pixels in flight → all outputs 0 next cycle, no stale pixel is emitted, and the next request gets a fresh result with `pix_count` restarting from 1.
- `sh_valid_out` forced high with nothing issued → `err=1` and held, `pix_valid` stays 0; `err` clears only on `rst`.
